// File: rtl/tribus_rr_driver.sv
// tribus_rr_driver
// Round-robin arbiter that hands one shared tri-state bus to one of CHANNELS
// requesters at a time. Each channel has an active-low output enable, in the
// style of a bufif0 cell. The block keeps a programmable all-Z gap between
// owners and can optionally limit how long one owner keeps the bus.
//
// Parameters:
//   WIDTH      bus width in bits (1..64)
//   CHANNELS   number of requesters (2..16)
//   TURNAROUND idle cycles with no driver between two owners (0..15)
//   MAX_HOLD   number of cycles before an owner is forced to release the bus
//              while another channel waits; 0 means no limit
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset
//   req      per-channel bus request, level sensitive
//   data_in  channel i data at bits [i*WIDTH +: WIDTH]
//   bus      shared tri-state bus
//   oe_n     active-low per-channel output enable
//   grant    registered one-hot owner
//   owner    encoded owner index, valid while busy
//   busy     high while a channel drives the bus
//
// Optional feature (macro TRIBUS_PARK_EN): while no channel owns the bus, an
// internal keeper drives the last value seen during DRIVE (0 after reset).
// oe_n is unaffected. When the macro is undefined, the bus floats (Z) outside
// DRIVE.

module tribus_rr_driver #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 0,
  localparam int IW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  inout  wire  [WIDTH-1:0]          bus,
  output logic [CHANNELS-1:0]       oe_n,
  output logic [CHANNELS-1:0]       grant,
  output logic [IW-1:0]             owner,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t              state, state_nxt;
  logic [CHANNELS-1:0] grant_nxt;
  logic [IW-1:0]       owner_nxt;
  logic [IW-1:0]       rr_ptr, rr_nxt;
  logic [15:0]         hold_cnt, hold_nxt;
  logic [3:0]          turn_cnt, turn_nxt;

  logic [IW-1:0]       arb_base;
  logic [IW-1:0]       arb_idx;
  logic                arb_found;
  logic                release_now;
  logic                do_arb;
  logic [WIDTH-1:0]    owner_data;
  int                  cand;

  // Index one past v, wrapping at CHANNELS. This also works when CHANNELS is
  // not a power of two.
  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    if (int'(v) == CHANNELS - 1) return '0;
    else                         return v + 1'b1;
  endfunction

  // Cyclic search for the first requester at or after the base index.
  // If a direct handover happens (TURNAROUND = 0), the search starts one past
  // the current owner. That owner is then checked last, so it cannot win
  // again while another channel is requesting.
  always_comb begin
    arb_base  = (state == DRIVE) ? inc_wrap(owner) : rr_ptr;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = int'(arb_base) + i;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!arb_found && req[IW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(cand);
      end
    end
  end

  // The owner releases the bus when its own request drops. It is also forced
  // off once the hold limit is reached, but only if some other channel is
  // waiting.
  always_comb begin
    release_now = !req[owner] ||
                  ((MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD) && (|(req & ~grant)));
  end

  // State register together with all other registered arbitration state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
    end
  end

  // Next-state logic. IDLE, the end of a gap, and a zero-gap release all
  // arbitrate the same way, so they share one do_arb path.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    do_arb    = 1'b0;

    unique case (state)
      IDLE: do_arb = 1'b1;
      DRIVE: begin
        if (release_now) begin
          grant_nxt = '0;
          rr_nxt    = inc_wrap(owner);
          if (TURNAROUND > 0) begin
            state_nxt = TURN;
            turn_nxt  = 4'(TURNAROUND);
          end else begin
            do_arb = 1'b1;
          end
        end else if (hold_cnt != 16'hFFFF) begin
          hold_nxt = hold_cnt + 16'd1;
        end
      end
      TURN: begin
        if (turn_cnt != 4'd0) turn_nxt = turn_cnt - 4'd1;
        if (turn_cnt <= 4'd1) do_arb = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (do_arb) begin
      if (arb_found) begin
        state_nxt          = DRIVE;
        grant_nxt          = '0;
        grant_nxt[arb_idx] = 1'b1;
        owner_nxt          = arb_idx;
        hold_nxt           = 16'd1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Outputs. grant is zero outside DRIVE, so oe_n is all ones then.
  always_comb begin
    busy       = (state == DRIVE);
    oe_n       = ~grant;
    owner_data = data_in[int'(owner)*WIDTH +: WIDTH];
  end

`ifdef TRIBUS_PARK_EN
  logic [WIDTH-1:0] park_q;

  // The keeper tracks the owner's data on every DRIVE cycle, so after a
  // release it holds the final value that was driven.
  always_ff @(posedge clk) begin
    if (!rst_n)              park_q <= '0;
    else if (state == DRIVE) park_q <= owner_data;
  end

  assign bus = busy ? owner_data : park_q;
`else
  assign bus = busy ? owner_data : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_tribus_rr_driver.sv
// tb_tribus_rr_driver
// Self-checking bench for tribus_rr_driver. It uses two instances:
//   dut_a: TURNAROUND=1, MAX_HOLD=3 (reset, grant, round robin, forced release,
//          reset in the middle of DRIVE)
//   dut_b: TURNAROUND=0, MAX_HOLD=0 (direct handover, combinational pass-through)
// Table rows are queued as expected results when they are driven. Each row is
// popped and compared one cycle later. A monitor checks every cycle that each
// instance has at most one enable low.
// Define TRIBUS_PARK_EN for both the bench and the RTL to check the bus keeper.

module tb_tribus_rr_driver;

  typedef struct {
    bit         sel;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] oe_n;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  logic        clk;
  logic        rst_a, rst_b;
  logic [3:0]  req_a, req_b;
  logic [31:0] data_in;
  wire  [7:0]  bus_a, bus_b;
  logic [3:0]  oe_a, oe_b, grant_a, grant_b;
  logic [1:0]  owner_a, owner_b;
  logic        busy_a, busy_b;

  logic [7:0]  ch_data [4];
  logic [7:0]  park_exp [2];
  vec_t        vecs[$];
  vec_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  bit          mon_en = 1'b0;

  tribus_rr_driver #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(1), .MAX_HOLD(3)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .data_in(data_in), .bus(bus_a),
    .oe_n(oe_a), .grant(grant_a), .owner(owner_a), .busy(busy_a)
  );

  tribus_rr_driver #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(0), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .data_in(data_in), .bus(bus_b),
    .oe_n(oe_b), .grant(grant_b), .owner(owner_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic vec_t mkv(input bit sel, input logic rst_n, input logic [3:0] rq,
                               input logic [3:0] g, input logic [1:0] o);
    vec_t r;
    r.sel   = sel;
    r.rst_n = rst_n;
    r.req   = rq;
    r.grant = g;
    r.oe_n  = ~g;
    r.busy  = |g;
    r.owner = o;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if (v.sel == 1'b0) begin
      rst_a = v.rst_n;
      req_a = v.req;
    end else begin
      rst_b = v.rst_n;
      req_b = v.req;
    end
    sb.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t       e;
    logic [3:0] g, o;
    logic [1:0] ow;
    logic       b;
    logic [7:0] bv;
    string      p;
    if (sb.size() == 0) begin
      cmp($sformatf("v%0d scoreboard_empty", idx), 8'd0, 8'd1);
      return;
    end
    e  = sb.pop_front();
    p  = $sformatf("v%0d%s", idx, e.sel ? "b" : "a");
    g  = e.sel ? grant_b : grant_a;
    o  = e.sel ? oe_b    : oe_a;
    ow = e.sel ? owner_b : owner_a;
    b  = e.sel ? busy_b  : busy_a;
    bv = e.sel ? bus_b   : bus_a;
    cmp({p, " grant"}, {4'd0, g}, {4'd0, e.grant});
    cmp({p, " oe_n"},  {4'd0, o}, {4'd0, e.oe_n});
    cmp({p, " busy"},  {7'd0, b}, {7'd0, e.busy});
    if (!e.rst_n) begin
      park_exp[e.sel] = 8'h00;
    end else if (e.busy) begin
      cmp({p, " owner"}, {6'd0, ow}, {6'd0, e.owner});
      cmp({p, " bus"}, bv, ch_data[e.owner]);
      park_exp[e.sel] = ch_data[e.owner];
    end
`ifdef TRIBUS_PARK_EN
    if (!e.busy) cmp({p, " park_bus"}, bv, park_exp[e.sel]);
`endif
  endtask

  // At most one enable may be low in any cycle, on both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      cmp("onehot_oe_a", {7'd0, ($countones(~oe_a) <= 1)}, 8'd1);
      cmp("onehot_oe_b", {7'd0, ($countones(~oe_b) <= 1)}, 8'd1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ch_data[0] = 8'h3C;
    ch_data[1] = 8'h11;
    ch_data[2] = 8'hA5;
    ch_data[3] = 8'h7E;
    park_exp[0] = 8'h00;
    park_exp[1] = 8'h00;
    data_in = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    rst_a = 1'b0; req_a = 4'b0000;
    rst_b = 1'b0; req_b = 4'b0000;

    // dut_a: reset, then a single grant to ch2 that holds with no competition.
    vecs.push_back(mkv(0, 0, 4'b0000, 4'b0000, 2'd0));
    vecs.push_back(mkv(0, 0, 4'b0000, 4'b0000, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0100, 4'b0100, 2'd2));
    vecs.push_back(mkv(0, 1, 4'b0100, 4'b0100, 2'd2));
    vecs.push_back(mkv(0, 1, 4'b0100, 4'b0100, 2'd2));
    vecs.push_back(mkv(0, 1, 4'b0100, 4'b0100, 2'd2));
    vecs.push_back(mkv(0, 1, 4'b0000, 4'b0000, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0000, 4'b0000, 2'd0));
    // Pointer is 3: the search wraps to ch0. ch0 is forced off after 3 cycles
    // and ch2 wins after the gap.
    vecs.push_back(mkv(0, 1, 4'b0101, 4'b0001, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0101, 4'b0001, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0101, 4'b0001, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0101, 4'b0000, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0101, 4'b0100, 2'd2));
    // All four requesting: owners 0,1,2,3,0, each for 3 cycles with 1 gap.
    vecs.push_back(mkv(0, 0, 4'b1111, 4'b0000, 2'd0));
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 3; k++)
        vecs.push_back(mkv(0, 1, 4'b1111, 4'(1 << ch), 2'(ch)));
      vecs.push_back(mkv(0, 1, 4'b1111, 4'b0000, 2'd0));
    end
    vecs.push_back(mkv(0, 1, 4'b1111, 4'b0001, 2'd0));
    // Reset during ch0 DRIVE while req[0] stays high, then ch0 is granted again.
    vecs.push_back(mkv(0, 0, 4'b0001, 4'b0000, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0001, 4'b0001, 2'd0));
    vecs.push_back(mkv(0, 1, 4'b0001, 4'b0001, 2'd0));
    // dut_b: zero-gap direct handovers.
    vecs.push_back(mkv(1, 0, 4'b0000, 4'b0000, 2'd0));
    vecs.push_back(mkv(1, 1, 4'b0010, 4'b0010, 2'd1));
    vecs.push_back(mkv(1, 1, 4'b1010, 4'b0010, 2'd1));
    vecs.push_back(mkv(1, 1, 4'b1000, 4'b1000, 2'd3));
    vecs.push_back(mkv(1, 1, 4'b1001, 4'b1000, 2'd3));
    vecs.push_back(mkv(1, 1, 4'b0001, 4'b0001, 2'd0));
    vecs.push_back(mkv(1, 1, 4'b0000, 4'b0000, 2'd0));
    vecs.push_back(mkv(1, 1, 4'b0110, 4'b0010, 2'd1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(i);
      mon_en = 1'b1;
    end

    // dut_b has ch1 driving. Changes to its data must reach the bus with no
    // clock edge in between.
    data_in[15:8] = 8'h5A;
    #1;
    cmp("passthru_5A", bus_b, 8'h5A);
    data_in[15:8] = ch_data[1];
    #1;
    cmp("passthru_restore", bus_b, ch_data[1]);
    cmp("passthru_busy", {7'd0, busy_b}, 8'd1);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
